// File: rtl/afifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO. It keeps the binary write
// pointer, publishes a registered Gray copy to the read domain, synchronises the
// read domain's Gray pointer, and derives full, almost-full, level and a sticky
// overflow flag from the two pointers.
module afifo_wr_ctrl #(
    parameter int DEPTH_BITS   = 10,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 2**DEPTH_BITS - 4
) (
    input  logic                  WR_CLK,
    input  logic                  WR_RST,
    input  logic                  WR_EN,
    input  logic                  OVF_CLR,
    input  logic [DEPTH_BITS:0]   RD_PTR_GRAY,
    output logic                  MEM_WE,
    output logic [DEPTH_BITS-1:0] WR_ADDR,
    output logic [DEPTH_BITS:0]   WR_PTR_GRAY,
    output logic                  WR_FULL,
    output logic                  WR_AFULL,
    output logic [DEPTH_BITS:0]   WR_LEVEL,
    output logic                  WR_OVF
);

    localparam int PW = DEPTH_BITS + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbinNext;
    logic [PW-1:0] wgrayNext;
    logic [PW-1:0] rgraySync [SYNC_STAGES];
    logic [PW-1:0] rgrayS;
    logic [PW-1:0] rbinS;
    logic [PW-1:0] levelNext;
    logic          accept;
    logic          fullNext;

    // The registered full flag already reflects any write at this edge, so it is
    // the only gate needed to make overrun impossible.
    assign accept    = WR_EN & ~WR_FULL;
    assign MEM_WE    = accept & ~WR_RST;
    assign WR_ADDR   = wbin[DEPTH_BITS-1:0];

    assign wbinNext  = wbin + {{DEPTH_BITS{1'b0}}, accept};
    assign wgrayNext = bin2gray(wbinNext);
    assign rgrayS    = rgraySync[SYNC_STAGES-1];
    assign rbinS     = gray2bin(rgrayS);
    assign levelNext = wbinNext - rbinS;

    // Full when the write pointer has lapped the read pointer exactly once:
    // in Gray code that is the top two bits inverted and the rest equal.
    assign fullNext  = (wgrayNext == {~rgrayS[PW-1:PW-2], rgrayS[PW-3:0]});

    // Read-pointer synchroniser: plain flop chain, no logic between stages.
    always_ff @(posedge WR_CLK or posedge WR_RST) begin
        if (WR_RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rgraySync[i] <= '0;
            end
        end else begin
            rgraySync[0] <= RD_PTR_GRAY;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rgraySync[i] <= rgraySync[i-1];
            end
        end
    end

    // Write pointer, published Gray pointer and the flags derived from them.
    always_ff @(posedge WR_CLK or posedge WR_RST) begin
        if (WR_RST) begin
            wbin        <= '0;
            WR_PTR_GRAY <= '0;
            WR_LEVEL    <= '0;
            WR_FULL     <= 1'b0;
            WR_AFULL    <= 1'b0;
        end else begin
            wbin        <= wbinNext;
            WR_PTR_GRAY <= wgrayNext;
            WR_LEVEL    <= levelNext;
            WR_FULL     <= fullNext;
            WR_AFULL    <= (levelNext >= AFULL_LVL);
        end
    end

    // Sticky overflow: a write attempt while full sets it, and setting beats
    // a simultaneous clear so no overflow event is ever lost.
    always_ff @(posedge WR_CLK or posedge WR_RST) begin
        if (WR_RST) begin
            WR_OVF <= 1'b0;
        end else if (WR_EN && WR_FULL) begin
            WR_OVF <= 1'b1;
        end else if (OVF_CLR) begin
            WR_OVF <= 1'b0;
        end
    end

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Bench for afifo_wr_ctrl with DEPTH_BITS=4, SYNC_STAGES=2, AFULL_THRESH=12:
// a directed vector table, hand-written wrap and reset sequences, and a
// randomised run checked against an occupancy-counting reference model.
module tb_afifo_wr_ctrl;

    logic       WR_CLK;
    logic       WR_RST;
    logic       WR_EN;
    logic       OVF_CLR;
    logic [4:0] RD_PTR_GRAY;
    logic       MEM_WE;
    logic [3:0] WR_ADDR;
    logic [4:0] WR_PTR_GRAY;
    logic       WR_FULL;
    logic       WR_AFULL;
    logic [4:0] WR_LEVEL;
    logic       WR_OVF;

    afifo_wr_ctrl #(
        .DEPTH_BITS   (4),
        .SYNC_STAGES  (2),
        .AFULL_THRESH (12)
    ) dut (
        .WR_CLK      (WR_CLK),
        .WR_RST      (WR_RST),
        .WR_EN       (WR_EN),
        .OVF_CLR     (OVF_CLR),
        .RD_PTR_GRAY (RD_PTR_GRAY),
        .MEM_WE      (MEM_WE),
        .WR_ADDR     (WR_ADDR),
        .WR_PTR_GRAY (WR_PTR_GRAY),
        .WR_FULL     (WR_FULL),
        .WR_AFULL    (WR_AFULL),
        .WR_LEVEL    (WR_LEVEL),
        .WR_OVF      (WR_OVF)
    );

    initial WR_CLK = 1'b0;
    always #5 WR_CLK = ~WR_CLK;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Gray code of a pointer value taken modulo 32 (5-bit pointer).
    function automatic logic [4:0] toGray(input int v);
        logic [4:0] b;
        b = 5'(v % 32);
        return b ^ (b >> 1);
    endfunction

    typedef struct {
        logic       en;
        logic       clr;
        logic [4:0] rdg;
        logic       we;
        logic [3:0] addr;
        logic [4:0] lvl;
        logic       full;
        logic       afull;
        logic       ovf;
    } rowT;

    rowT tbl [26];

    function automatic rowT mkRow(input logic en, clr, input logic [4:0] rdg,
                                  input logic we, input logic [3:0] addr,
                                  input logic [4:0] lvl, input logic full, afull, ovf);
        rowT r;
        r.en = en; r.clr = clr; r.rdg = rdg; r.we = we; r.addr = addr;
        r.lvl = lvl; r.full = full; r.afull = afull; r.ovf = ovf;
        return r;
    endfunction

    // reference model state: unbounded write/read counts
    int mw;
    int rdc;
    int rq[$];
    bit fullM;
    bit ovfM;

    task automatic doReset();
        WR_RST      = 1'b1;
        WR_EN       = 1'b0;
        OVF_CLR     = 1'b0;
        RD_PTR_GRAY = '0;
        repeat (3) @(posedge WR_CLK);
        @(negedge WR_CLK);
        WR_RST = 1'b0;
        mw = 0; rdc = 0; rq.delete(); fullM = 0; ovfM = 0;
    endtask

    initial begin
        logic [4:0] prevGray;
        int lvl;
        int synced;
        bit en;
        bit clr;

        WR_RST = 1'b0; WR_EN = 1'b1; OVF_CLR = 1'b0; RD_PTR_GRAY = '0;

        // asynchronous reset takes effect without a clock edge
        #2 WR_RST = 1'b1;
        #1;
        chk("rst_we",    MEM_WE,      0);
        chk("rst_addr",  WR_ADDR,     0);
        chk("rst_gray",  WR_PTR_GRAY, 0);
        chk("rst_full",  WR_FULL,     0);
        chk("rst_afull", WR_AFULL,    0);
        chk("rst_level", WR_LEVEL,    0);
        chk("rst_ovf",   WR_OVF,      0);

        // directed table: fill, overflow, clear, read step, refill
        for (int i = 0; i < 16; i++)
            tbl[i] = mkRow(1, 0, 5'd0, 1, 4'(i), 5'(i + 1), i == 15, i >= 11, 0);
        for (int i = 16; i < 19; i++)
            tbl[i] = mkRow(1, 0, 5'd0, 0, 4'd0, 5'd16, 1, 1, 1);
        tbl[19] = mkRow(0, 1, 5'd0, 0, 4'd0, 5'd16, 1, 1, 0);
        tbl[20] = mkRow(1, 1, 5'd0, 0, 4'd0, 5'd16, 1, 1, 1);
        tbl[21] = mkRow(0, 0, 5'd1, 0, 4'd0, 5'd16, 1, 1, 1);
        tbl[22] = mkRow(0, 0, 5'd1, 0, 4'd0, 5'd16, 1, 1, 1);
        tbl[23] = mkRow(0, 0, 5'd1, 0, 4'd0, 5'd15, 0, 1, 1);
        tbl[24] = mkRow(1, 0, 5'd1, 1, 4'd0, 5'd16, 1, 1, 1);
        tbl[25] = mkRow(0, 1, 5'd1, 0, 4'd1, 5'd16, 1, 1, 0);

        doReset();
        for (int r = 0; r < 26; r++) begin
            @(negedge WR_CLK);
            WR_EN = tbl[r].en; OVF_CLR = tbl[r].clr; RD_PTR_GRAY = tbl[r].rdg;
            #1;
            chk($sformatf("row%0d_we", r),   MEM_WE,  tbl[r].we);
            chk($sformatf("row%0d_addr", r), WR_ADDR, tbl[r].addr);
            @(posedge WR_CLK); #1;
            chk($sformatf("row%0d_level", r), WR_LEVEL, tbl[r].lvl);
            chk($sformatf("row%0d_full", r),  WR_FULL,  tbl[r].full);
            chk($sformatf("row%0d_afull", r), WR_AFULL, tbl[r].afull);
            chk($sformatf("row%0d_ovf", r),   WR_OVF,   tbl[r].ovf);
        end

        // 40 writes with the reader trailing by 8: pointer wraps 31->0
        doReset();
        prevGray = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge WR_CLK);
            WR_EN = 1'b1; OVF_CLR = 1'b0;
            RD_PTR_GRAY = toGray((k > 8) ? k - 8 : 0);
            #1;
            chk($sformatf("wrap%0d_we", k),   MEM_WE,  1);
            chk($sformatf("wrap%0d_addr", k), WR_ADDR, k % 16);
            @(posedge WR_CLK); #1;
            chk($sformatf("wrap%0d_gray", k),  WR_PTR_GRAY, toGray(k + 1));
            chk($sformatf("wrap%0d_1bit", k),  $countones(WR_PTR_GRAY ^ prevGray), 1);
            chk($sformatf("wrap%0d_full", k),  WR_FULL, 0);
            prevGray = WR_PTR_GRAY;
        end

        // reset in the middle of a burst, off the clock edge
        doReset();
        @(negedge WR_CLK);
        WR_EN = 1'b1;
        repeat (7) @(posedge WR_CLK);
        #3 WR_RST = 1'b1;
        #1;
        chk("midrst_we",    MEM_WE,      0);
        chk("midrst_addr",  WR_ADDR,     0);
        chk("midrst_gray",  WR_PTR_GRAY, 0);
        chk("midrst_full",  WR_FULL,     0);
        chk("midrst_afull", WR_AFULL,    0);
        chk("midrst_level", WR_LEVEL,    0);
        chk("midrst_ovf",   WR_OVF,      0);
        repeat (2) @(posedge WR_CLK);
        @(negedge WR_CLK);
        WR_RST = 1'b0;
        #1;
        chk("postrst_we",   MEM_WE,  1);
        chk("postrst_addr", WR_ADDR, 0);
        @(posedge WR_CLK); #1;
        chk("postrst_level", WR_LEVEL, 1);

        // randomised traffic against the occupancy model
        doReset();
        for (int i = 0; i < 800; i++) begin
            @(negedge WR_CLK);
            en  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 9) == 0);
            if (rdc < mw && $urandom_range(0, 9) < (((i / 100) % 2) ? 2 : 8)) rdc++;
            WR_EN = en; OVF_CLR = clr; RD_PTR_GRAY = toGray(rdc);
            #1;
            chk("rnd_we",   MEM_WE,  en && !fullM);
            chk("rnd_addr", WR_ADDR, mw % 16);
            @(posedge WR_CLK);
            synced = (rq.size() >= 2) ? rq[rq.size() - 2] : 0;
            rq.push_back(rdc);
            if (rq.size() > 4) void'(rq.pop_front());
            ovfM = (en && fullM) ? 1'b1 : (clr ? 1'b0 : ovfM);
            if (en && !fullM) mw++;
            lvl   = mw - synced;
            fullM = (lvl == 16);
            #1;
            chk("rnd_level", WR_LEVEL,    lvl);
            chk("rnd_full",  WR_FULL,     fullM);
            chk("rnd_afull", WR_AFULL,    lvl >= 12);
            chk("rnd_ovf",   WR_OVF,      ovfM);
            chk("rnd_gray",  WR_PTR_GRAY, toGray(mw));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/afifo_wr_ctrl.md
AFIFO_WR_CTRL -- requirements
Module: afifo_wr_ctrl

Interface
REQ-001 Parameter DEPTH_BITS, 10, log2 of FIFO entry count (range 2..16).
REQ-002 Parameter SYNC_STAGES, 2, flops in read-pointer synchroniser (range 2..4).
REQ-003 Parameter AFULL_THRESH, 2**DEPTH_BITS-4, occupancy at which WR_AFULL asserts (range 1..2**DEPTH_BITS).
REQ-004 WR_CLK  input  1  write-domain clock; all logic is on its rising edge.
REQ-005 WR_RST  input  1  reset, asynchronous, active-high.
REQ-006 WR_EN  input  1  write request.
REQ-007 OVF_CLR  input  1  synchronous clear of WR_OVF.
REQ-008 RD_PTR_GRAY  input  DEPTH_BITS+1  read pointer, Gray-coded, from the read clock domain.
REQ-009 MEM_WE  output  1  RAM write strobe.
REQ-010 WR_ADDR  output  DEPTH_BITS  RAM write address (binary).
REQ-011 WR_PTR_GRAY  output  DEPTH_BITS+1  registered Gray write pointer, sent to the read domain.
REQ-012 WR_FULL  output  1  FIFO full.
REQ-013 WR_AFULL  output  1  occupancy >= AFULL_THRESH.
REQ-014 WR_LEVEL  output  DEPTH_BITS+1  write-side occupancy estimate, 0..2**DEPTH_BITS.
REQ-015 WR_OVF  output  1  sticky overflow flag.

Function
REQ-016 Write accepted when WR_EN=1 and WR_FULL=0; MEM_WE SHALL equal WR_EN & ~WR_FULL, combinational.
REQ-017 Binary pointer wbin (DEPTH_BITS+1 bits) SHALL increment by 1 on each accepted write; it wraps modulo 2**(DEPTH_BITS+1).
REQ-018 WR_ADDR SHALL equal wbin[DEPTH_BITS-1:0] in the current cycle, before the increment.
REQ-019 WR_PTR_GRAY SHALL be registered and SHALL equal (wbin>>1)^wbin of the post-edge wbin, so only one bit changes per write.
REQ-020 RD_PTR_GRAY SHALL pass through a SYNC_STAGES-deep flop chain with no logic between stages; the output is rgray_s.
REQ-021 rbin_s SHALL be the Gray-to-binary conversion of rgray_s.
REQ-022 WR_FULL SHALL be registered, set from the next-cycle Gray pointer: full when its top two bits are the inverse of rgray_s and all other bits are equal.
REQ-023 A write that fills the FIFO SHALL raise WR_FULL at the same edge the pointer advances; no write beyond 2**DEPTH_BITS entries is ever accepted.
REQ-024 WR_FULL SHALL deassert no later than SYNC_STAGES+1 WR_CLK edges after RD_PTR_GRAY advances (pessimistic, never early).
REQ-025 WR_LEVEL SHALL be registered and equal next-wbin minus rbin_s, modulo 2**(DEPTH_BITS+1).
REQ-026 WR_AFULL SHALL be registered and equal (next WR_LEVEL >= AFULL_THRESH); it stays asserted while WR_FULL=1.
REQ-027 WR_OVF SHALL be set at the edge following any cycle with WR_EN=1 and WR_FULL=1.
REQ-028 WR_OVF SHALL be cleared by OVF_CLR=1; if set and clear occur in the same cycle, set wins.
REQ-029 A rejected write SHALL change no pointer, WR_LEVEL, or MEM_WE.
REQ-030 Pointer wrap (wbin from all-ones to 0) SHALL be seamless: full/level stay correct across the wrap.

Reset
REQ-031 While WR_RST=1, and immediately on its assertion: wbin, WR_PTR_GRAY, sync chain, WR_LEVEL = 0; WR_FULL, WR_AFULL, WR_OVF = 0.
REQ-032 During reset, MEM_WE SHALL be 0 regardless of WR_EN.
REQ-033 Reset asserted mid-burst SHALL abandon the burst; the first write accepted after release SHALL use WR_ADDR=0.
REQ-034 Release of WR_RST SHALL be synchronised externally to WR_CLK; the block makes no recovery/removal guarantee.

Verification (DEPTH_BITS=4, SYNC_STAGES=2, AFULL_THRESH=12)
REQ-035 Reset, RD_PTR_GRAY=0, 16 back-to-back writes -> WR_ADDR 0..15; WR_AFULL rises after the 12th write; WR_FULL rises after the 16th write; WR_LEVEL=16.
REQ-036 Full FIFO, WR_EN held 3 more cycles -> MEM_WE=0, WR_ADDR stays 0; WR_OVF=1 one edge later and remains 1; an OVF_CLR pulse with WR_EN=0 -> WR_OVF=0.
REQ-037 Full FIFO, RD_PTR_GRAY stepped 0->1 (Gray of 1) -> WR_FULL=0 within 3 edges; WR_LEVEL=15; the next write uses WR_ADDR=0 and re-asserts WR_FULL.
REQ-038 Run 40 writes with the read side tracking at 8 entries behind -> continuous wrap through wbin 31->0; WR_PTR_GRAY changes exactly 1 bit per write; WR_FULL is never asserted.
REQ-039 WR_RST pulsed mid-burst after 7 writes, asynchronous to WR_CLK -> all outputs 0 immediately; after release, the first write uses WR_ADDR=0.
REQ-040 Same-cycle OVF_CLR=1 with WR_EN=1 while full -> WR_OVF remains 1.
